// File: rtl/spi_flash_slave_model_pkg.sv
`default_nettype none
// ============================================================================
// Module      : spi_flash_pkg
// Description : Opcodes, status-register bit positions and state types shared
//               by the SPI flash slave model and the flash master controllers.
// Revision    : 1.0 - initial release
// ============================================================================
package spi_flash_pkg;

    localparam logic [7:0] c_op_wren = 8'h06;
    localparam logic [7:0] c_op_wrdi = 8'h04;
    localparam logic [7:0] c_op_be   = 8'hC7;
    localparam logic [7:0] c_op_rdsr = 8'h05;

    localparam int c_sr_wip = 0;
    localparam int c_sr_wel = 1;

    typedef enum logic [1:0] {
        BUS_IDLE     = 2'd0,
        BUS_CMD      = 2'd1,
        BUS_RDSR_OUT = 2'd2,
        BUS_DISCARD  = 2'd3
    } bus_state_t;

    typedef enum logic [0:0] {
        ERASE_READY   = 1'b0,
        ERASE_ERASING = 1'b1
    } erase_state_t;

    // Status register image as seen on the wire during RDSR.
    function automatic logic [7:0] status_byte(input logic wel, input logic wip);
        logic [7:0] s;
        s           = '0;
        s[c_sr_wel] = wel;
        s[c_sr_wip] = wip;
        return s;
    endfunction

    // Opcodes that modify state and therefore must be exactly 8 bits long.
    function automatic logic is_write_op(input logic [7:0] op);
        return (op == c_op_wren) || (op == c_op_wrdi) || (op == c_op_be);
    endfunction

endpackage
`default_nettype wire

// File: rtl/spi_flash_slave_model_if.sv
`default_nettype none
// ============================================================================
// Module      : spi_flash_slave_model_if
// Description : SPI bus pins between a flash master and the slave model.
// Revision    : 1.0 - initial release
// ============================================================================
interface spi_flash_slave_model_if;
    logic sck;
    logic cs_n;
    logic mosi;
    logic miso;

    modport master (output sck, output cs_n, output mosi, input miso);
    modport slave  (input sck, input cs_n, input mosi, output miso);
endinterface
`default_nettype wire

// File: rtl/spi_flash_slave_model_sync.sv
`default_nettype none
// ============================================================================
// Module      : spi_slave_sync
// Description : Two-flop synchronizers for sck and cs_n with edge detection;
//               mosi is carried through an equal-depth pipeline so that the
//               value presented with sck_rise is the one sampled at that edge.
// Revision    : 1.0 - initial release
// ============================================================================
module spi_slave_sync (
    input  wire logic sys_clk,
    input  wire logic sys_rst_n,
    input  wire logic sck,
    input  wire logic cs_n,
    input  wire logic mosi,
    output logic      sck_rise,
    output logic      sck_fall,
    output logic      cs_rise,
    output logic      cs_fall,
    output logic      mosi_sync
);
    // [0] first sync stage, [1] second sync stage, [2] previous value of [1]
    logic [2:0] sck_q, sck_d;
    logic [2:0] cs_q,  cs_d;
    logic [1:0] mosi_q, mosi_d;

    // Next values of the synchronizer pipelines.
    always_comb begin
        sck_d  = {sck_q[1:0], sck};
        cs_d   = {cs_q[1:0], cs_n};
        mosi_d = {mosi_q[0], mosi};
    end

    // cs_n pipeline resets low: a frame already running at reset release then
    // produces no falling edge, and a high cs_n only yields a harmless rise.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            sck_q  <= '0;
            cs_q   <= '0;
            mosi_q <= '0;
        end else begin
            sck_q  <= sck_d;
            cs_q   <= cs_d;
            mosi_q <= mosi_d;
        end
    end

    assign sck_rise  =  sck_q[1] & ~sck_q[2];
    assign sck_fall  = ~sck_q[1] &  sck_q[2];
    assign cs_rise   =  cs_q[1]  & ~cs_q[2];
    assign cs_fall   = ~cs_q[1]  &  cs_q[2];
    assign mosi_sync =  mosi_q[1];

endmodule
`default_nettype wire

// File: rtl/spi_flash_slave_model.sv
`default_nettype none
// ============================================================================
// Module      : spi_flash_slave_model
// Description : Behavioural SPI flash slave supporting WREN, WRDI, BE and
//               RDSR, oversampling the SPI bus in the sys_clk domain.
// Revision    : 1.0 - initial release
// ============================================================================
module spi_flash_slave_model
    import spi_flash_pkg::*;
#(
    parameter int ERASE_CYCLES = 1000
) (
    input  wire logic               sys_clk,
    input  wire logic               sys_rst_n,
    spi_flash_slave_model_if.slave  spi,
    output logic                    wel,
    output logic                    wip,
    output logic [7:0]              cmd_byte,
    output logic                    cmd_valid,
    output logic                    erase_start,
    output logic                    erase_done,
    output logic                    cmd_err
);
    localparam int                 c_cnt_w    = $clog2(ERASE_CYCLES + 1);
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(ERASE_CYCLES - 1);

    logic w_sck_rise, w_sck_fall, w_cs_rise, w_cs_fall, w_mosi;
    logic w_wip;
    logic [7:0] w_status;
    logic w_wren_exec, w_wrdi_exec, w_be_accept;

    bus_state_t         bus_state_q,  bus_state_d;
    logic [3:0]         bit_cnt_q,    bit_cnt_d;
    logic [7:0]         shift_q,      shift_d;
    logic [2:0]         tx_cnt_q,     tx_cnt_d;
    logic [7:0]         cmd_byte_q,   cmd_byte_d;
    logic               cmd_valid_q,  cmd_valid_d;
    logic               cmd_err_q,    cmd_err_d;
    logic               miso_q,       miso_d;
    logic               wel_q,        wel_d;
    erase_state_t       erase_state_q, erase_state_d;
    logic [c_cnt_w-1:0] erase_cnt_q,  erase_cnt_d;
    logic               erase_start_q, erase_start_d;
    logic               erase_done_q, erase_done_d;

    spi_slave_sync u_sync (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .sck       (spi.sck),
        .cs_n      (spi.cs_n),
        .mosi      (spi.mosi),
        .sck_rise  (w_sck_rise),
        .sck_fall  (w_sck_fall),
        .cs_rise   (w_cs_rise),
        .cs_fall   (w_cs_fall),
        .mosi_sync (w_mosi)
    );

    assign w_wip    = (erase_state_q == ERASE_ERASING);
    assign w_status = status_byte(wel_q, w_wip);

    // Bus FSM: opcode shifting, RDSR status shifting and command execution at frame end.
    always_comb begin
        bus_state_d = bus_state_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        tx_cnt_d    = tx_cnt_q;
        cmd_byte_d  = cmd_byte_q;
        cmd_valid_d = 1'b0;
        cmd_err_d   = 1'b0;
        miso_d      = miso_q;
        w_wren_exec = 1'b0;
        w_wrdi_exec = 1'b0;
        w_be_accept = 1'b0;

        if (w_cs_rise) begin
            bus_state_d = BUS_IDLE;
            if (bus_state_q != BUS_IDLE) begin
                if (bit_cnt_q < 4'd8) begin
                    cmd_err_d = 1'b1;
                end else if (is_write_op(cmd_byte_q)) begin
                    // Mutating commands are silently dropped while busy.
                    if (!w_wip) begin
                        if (bit_cnt_q != 4'd8) begin
                            cmd_err_d = 1'b1;
                        end else begin
                            w_wren_exec = (cmd_byte_q == c_op_wren);
                            w_wrdi_exec = (cmd_byte_q == c_op_wrdi);
                            w_be_accept = (cmd_byte_q == c_op_be) && wel_q;
                        end
                    end
                end else if (cmd_byte_q != c_op_rdsr) begin
                    cmd_err_d = 1'b1;
                end
            end
        end else if (w_cs_fall) begin
            bus_state_d = BUS_CMD;
            bit_cnt_d   = 4'd0;
            shift_d     = 8'h00;
        end else begin
            if (w_sck_rise && (bus_state_q != BUS_IDLE) && (bit_cnt_q != 4'd15)) begin
                bit_cnt_d = bit_cnt_q + 4'd1;
            end
            case (bus_state_q)
                BUS_CMD: begin
                    if (w_sck_rise) begin
                        shift_d = {shift_q[6:0], w_mosi};
                        if (bit_cnt_q == 4'd7) begin
                            cmd_byte_d  = {shift_q[6:0], w_mosi};
                            cmd_valid_d = 1'b1;
                            tx_cnt_d    = 3'd0;
                            bus_state_d = ({shift_q[6:0], w_mosi} == c_op_rdsr) ?
                                          BUS_RDSR_OUT : BUS_DISCARD;
                        end
                    end
                end
                BUS_RDSR_OUT: begin
                    if (w_sck_fall) begin
                        // A fresh status snapshot is taken at every byte boundary.
                        if (tx_cnt_q == 3'd0) begin
                            miso_d  = w_status[7];
                            shift_d = {w_status[6:0], 1'b0};
                        end else begin
                            miso_d  = shift_q[7];
                            shift_d = {shift_q[6:0], 1'b0};
                        end
                        tx_cnt_d = tx_cnt_q + 3'd1;
                    end
                end
                default: ;
            endcase
        end

        if (bus_state_d != BUS_RDSR_OUT) begin
            miso_d = 1'b0;
        end
    end

    // Erase FSM and write-enable latch; completion clears wel and wip together.
    always_comb begin
        erase_state_d = erase_state_q;
        erase_cnt_d   = erase_cnt_q;
        erase_start_d = 1'b0;
        erase_done_d  = 1'b0;
        wel_d         = wel_q;

        if (w_wren_exec) wel_d = 1'b1;
        if (w_wrdi_exec) wel_d = 1'b0;

        case (erase_state_q)
            ERASE_READY: begin
                if (w_be_accept) begin
                    erase_state_d = ERASE_ERASING;
                    erase_cnt_d   = '0;
                    erase_start_d = 1'b1;
                end
            end
            ERASE_ERASING: begin
                if (erase_cnt_q == c_cnt_last) begin
                    erase_state_d = ERASE_READY;
                    erase_cnt_d   = '0;
                    erase_done_d  = 1'b1;
                    wel_d         = 1'b0;
                end else begin
                    erase_cnt_d = erase_cnt_q + c_cnt_w'(1);
                end
            end
            default: erase_state_d = ERASE_READY;
        endcase
    end

    // State register for both FSMs; reset aborts any frame or erase at once.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            bus_state_q   <= BUS_IDLE;
            bit_cnt_q     <= '0;
            shift_q       <= '0;
            tx_cnt_q      <= '0;
            cmd_byte_q    <= '0;
            cmd_valid_q   <= 1'b0;
            cmd_err_q     <= 1'b0;
            miso_q        <= 1'b0;
            wel_q         <= 1'b0;
            erase_state_q <= ERASE_READY;
            erase_cnt_q   <= '0;
            erase_start_q <= 1'b0;
            erase_done_q  <= 1'b0;
        end else begin
            bus_state_q   <= bus_state_d;
            bit_cnt_q     <= bit_cnt_d;
            shift_q       <= shift_d;
            tx_cnt_q      <= tx_cnt_d;
            cmd_byte_q    <= cmd_byte_d;
            cmd_valid_q   <= cmd_valid_d;
            cmd_err_q     <= cmd_err_d;
            miso_q        <= miso_d;
            wel_q         <= wel_d;
            erase_state_q <= erase_state_d;
            erase_cnt_q   <= erase_cnt_d;
            erase_start_q <= erase_start_d;
            erase_done_q  <= erase_done_d;
        end
    end

    assign spi.miso    = miso_q;
    assign wel         = wel_q;
    assign wip         = w_wip;
    assign cmd_byte    = cmd_byte_q;
    assign cmd_valid   = cmd_valid_q;
    assign cmd_err     = cmd_err_q;
    assign erase_start = erase_start_q;
    assign erase_done  = erase_done_q;

endmodule
`default_nettype wire
